// File: rtl/ocx_tlx_framer_cmd_sched.sv
// Command scheduler between the TL command FIFO and the flit packer.
// Pops the FIFO head when the selected VC and the DCP0 pool hold enough
// credits, registers the command behind a valid/ack handshake, and tracks
// the three TL credit counters with saturation on overflow.
module ocx_tlx_framer_cmd_sched #(
  parameter int CREDIT_WIDTH = 6,
  parameter int CMD_WIDTH    = 172
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [CMD_WIDTH-1:0]    fifo_data,
  input  logic                    fifo_data_available,
  output logic                    fifo_rd_done,
  input  logic                    credit_init_valid,
  input  logic [CREDIT_WIDTH-1:0] credit_init_vc0,
  input  logic [CREDIT_WIDTH-1:0] credit_init_vc3,
  input  logic [CREDIT_WIDTH-1:0] credit_init_dcp0,
  input  logic [3:0]              vc0_credit_return,
  input  logic [3:0]              vc3_credit_return,
  input  logic [3:0]              dcp0_credit_return,
  input  logic                    pause,
  output logic                    cmd_valid,
  output logic [CMD_WIDTH-1:0]    cmd_data,
  input  logic                    cmd_ack,
  output logic [CREDIT_WIDTH-1:0] vc0_credits,
  output logic [CREDIT_WIDTH-1:0] vc3_credits,
  output logic [CREDIT_WIDTH-1:0] dcp0_credits,
  output logic                    credit_overflow_error
);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_PAUSED} state_t;

  localparam int SW = CREDIT_WIDTH + 1;

  state_t                  r_state, w_state_nxt;
  logic [CREDIT_WIDTH-1:0] r_vc0, r_vc3, r_dcp0;
  logic                    r_ovf;
  logic                    r_valid;
  logic [CMD_WIDTH-1:0]    r_data;

  logic                    w_vc3_sel;
  logic [1:0]              w_dc;
  logic                    w_vc_ok, w_dcp_ok, w_out_free, w_issue, w_load;
  logic [CREDIT_WIDTH-1:0] w_vc0_base, w_vc3_base, w_dcp0_base;
  logic [SW-1:0]           w_vc0_sum, w_vc3_sum, w_dcp0_sum;
  logic [1:0]              w_vc0_used, w_vc3_used, w_dcp0_used;

  // Head-of-FIFO decode: VC select and number of data credits required.
  assign w_vc3_sel  = fifo_data[CMD_WIDTH-1];
  assign w_dc       = fifo_data[CMD_WIDTH-2 -: 2];
  assign w_vc_ok    = w_vc3_sel ? (r_vc3 != '0) : (r_vc0 != '0);
  assign w_dcp_ok   = (r_dcp0 >= {{(CREDIT_WIDTH-2){1'b0}}, w_dc}) && (w_dc != 2'd3);
  assign w_out_free = !r_valid || cmd_ack;
  assign w_issue    = (r_state == ST_RUN) && fifo_data_available && w_vc_ok &&
                      w_dcp_ok && w_out_free;
  assign fifo_rd_done = w_issue;

  // Credit arithmetic: initial load replaces the current value, returns
  // are added on top, consumption is subtracted, all one bit wider so a
  // carry out of the top flags saturation.
  assign w_load      = (r_state == ST_INIT) && credit_init_valid;
  assign w_vc0_base  = w_load ? credit_init_vc0  : r_vc0;
  assign w_vc3_base  = w_load ? credit_init_vc3  : r_vc3;
  assign w_dcp0_base = w_load ? credit_init_dcp0 : r_dcp0;
  assign w_vc0_used  = {1'b0, w_issue & ~w_vc3_sel};
  assign w_vc3_used  = {1'b0, w_issue &  w_vc3_sel};
  assign w_dcp0_used = w_issue ? w_dc : 2'd0;
  assign w_vc0_sum   = {1'b0, w_vc0_base}  + SW'(vc0_credit_return)  - SW'(w_vc0_used);
  assign w_vc3_sum   = {1'b0, w_vc3_base}  + SW'(vc3_credit_return)  - SW'(w_vc3_used);
  assign w_dcp0_sum  = {1'b0, w_dcp0_base} + SW'(dcp0_credit_return) - SW'(w_dcp0_used);

  // Next-state logic for the INIT/RUN/PAUSED controller.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:   if (credit_init_valid) w_state_nxt = ST_RUN;
      ST_RUN:    if (pause)             w_state_nxt = ST_PAUSED;
      ST_PAUSED: if (!pause)            w_state_nxt = ST_RUN;
      default:                          w_state_nxt = ST_INIT;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_INIT;
    else          r_state <= w_state_nxt;
  end

  // Credit counters with saturation; overflow flag pulses alongside.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vc0  <= '0;
      r_vc3  <= '0;
      r_dcp0 <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_vc0  <= w_vc0_sum[CREDIT_WIDTH]  ? '1 : w_vc0_sum[CREDIT_WIDTH-1:0];
      r_vc3  <= w_vc3_sum[CREDIT_WIDTH]  ? '1 : w_vc3_sum[CREDIT_WIDTH-1:0];
      r_dcp0 <= w_dcp0_sum[CREDIT_WIDTH] ? '1 : w_dcp0_sum[CREDIT_WIDTH-1:0];
      r_ovf  <= w_vc0_sum[CREDIT_WIDTH] | w_vc3_sum[CREDIT_WIDTH] |
                w_dcp0_sum[CREDIT_WIDTH];
    end
  end

  // Output holding register: load on issue, drop valid on a bare ack.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_issue) begin
      r_valid <= 1'b1;
      r_data  <= fifo_data;
    end else if (cmd_ack) begin
      r_valid <= 1'b0;
    end
  end

  assign cmd_valid             = r_valid;
  assign cmd_data              = r_data;
  assign vc0_credits           = r_vc0;
  assign vc3_credits           = r_vc3;
  assign dcp0_credits          = r_dcp0;
  assign credit_overflow_error = r_ovf;

endmodule

// File: tb/tb_ocx_tlx_framer_cmd_sched.sv
// Directed bench for the command scheduler: a queue models the upstream
// FIFO, popped commands are pushed to a scoreboard and compared when the
// packer side acknowledges them.
module tb_ocx_tlx_framer_cmd_sched;
  localparam int CRW = 6;
  localparam int CW  = 172;

  logic           clock = 1'b0;
  logic           reset_n = 1'b1;
  logic [CW-1:0]  fifo_data = '0;
  logic           fifo_data_available = 1'b0;
  logic           fifo_rd_done;
  logic           credit_init_valid = 1'b0;
  logic [CRW-1:0] credit_init_vc0 = '0, credit_init_vc3 = '0, credit_init_dcp0 = '0;
  logic [3:0]     vc0_credit_return = '0, vc3_credit_return = '0, dcp0_credit_return = '0;
  logic           pause = 1'b0;
  logic           cmd_valid;
  logic [CW-1:0]  cmd_data;
  logic           cmd_ack = 1'b0;
  logic [CRW-1:0] vc0_credits, vc3_credits, dcp0_credits;
  logic           credit_overflow_error;

  ocx_tlx_framer_cmd_sched #(.CREDIT_WIDTH(CRW), .CMD_WIDTH(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .fifo_data(fifo_data), .fifo_data_available(fifo_data_available),
    .fifo_rd_done(fifo_rd_done),
    .credit_init_valid(credit_init_valid), .credit_init_vc0(credit_init_vc0),
    .credit_init_vc3(credit_init_vc3), .credit_init_dcp0(credit_init_dcp0),
    .vc0_credit_return(vc0_credit_return), .vc3_credit_return(vc3_credit_return),
    .dcp0_credit_return(dcp0_credit_return), .pause(pause),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ack(cmd_ack),
    .vc0_credits(vc0_credits), .vc3_credits(vc3_credits), .dcp0_credits(dcp0_credits),
    .credit_overflow_error(credit_overflow_error)
  );

  always #5 clock = ~clock;

  int            n_chk = 0, n_pass = 0, n_pop = 0, ncyc = 0;
  bit            pend = 1'b0;
  logic [CW-1:0] fq[$];
  logic [CW-1:0] exp_q[$];
  int            pop_at[$];

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [CW-1:0] mk(input bit vc3, input logic [1:0] dc, input int tag);
    logic [CW-1:0] v;
    v = '0;
    v[63:0] = {tag, ~tag};
    v[CW-2 -: 2] = dc;
    v[CW-1] = vc3;
    return v;
  endfunction

  task automatic refresh();
    fifo_data_available = (fq.size() > 0);
    fifo_data = (fq.size() > 0) ? fq[0] : '0;
  endtask

  task automatic push(input logic [CW-1:0] v);
    fq.push_back(v);
    refresh();
  endtask

  // One clock: sample at the falling edge, then step past the rising edge.
  task automatic cyc();
    @(negedge clock);
    chk("rd_without_avail", fifo_rd_done & ~fifo_data_available, 0);
    if (fifo_rd_done && fq.size() > 0) begin
      exp_q.push_back(fq[0]);
      pend = 1'b1;
      n_pop++;
      pop_at.push_back(ncyc);
    end
    if (cmd_valid && cmd_ack) begin
      chk("sb_nonempty", exp_q.size() == 0, 0);
      if (exp_q.size() > 0) chk("sb_data", cmd_data, exp_q.pop_front());
    end
    @(posedge clock);
    #1;
    ncyc++;
    if (pend) void'(fq.pop_front());
    pend = 1'b0;
    refresh();
  endtask

  initial begin
    int n0;
    logic [CW-1:0] ce, cf;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_data", cmd_data, 0);
    chk("rst_vc0", vc0_credits, 0);
    chk("rst_dcp0", dcp0_credits, 0);
    chk("rst_ovf", credit_overflow_error, 0);
    chk("rst_rd", fifo_rd_done, 0);
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;

    // Credit init 2/0/1, three VC0 commands, ack tied high
    cmd_ack = 1'b1;
    credit_init_vc0 = 6'd2; credit_init_vc3 = 6'd0; credit_init_dcp0 = 6'd1;
    credit_init_valid = 1'b1;
    push(mk(0, 0, 1)); push(mk(0, 0, 2)); push(mk(0, 0, 3));
    cyc();
    credit_init_valid = 1'b0;
    chk("init_vc0", vc0_credits, 2);
    chk("init_dcp0", dcp0_credits, 1);
    n0 = n_pop;
    repeat (4) cyc();
    chk("two_pops", n_pop - n0, 2);
    chk("pops_back_to_back", pop_at[pop_at.size()-1] - pop_at[pop_at.size()-2], 1);
    chk("vc0_empty", vc0_credits, 0);
    chk("third_held", fq.size(), 1);
    vc0_credit_return = 4'd1;
    cyc();
    vc0_credit_return = 4'd0;
    repeat (2) cyc();
    chk("third_popped", fq.size(), 0);
    chk("vc0_after_third", vc0_credits, 0);

    // Data-credit shortage
    vc0_credit_return = 4'd4;
    cyc();
    vc0_credit_return = 4'd0;
    push(mk(0, 2, 4));
    n0 = n_pop;
    repeat (3) cyc();
    chk("dcp_short_no_pop", n_pop - n0, 0);
    chk("dcp_short_val", dcp0_credits, 1);
    dcp0_credit_return = 4'd1;
    cyc();
    dcp0_credit_return = 4'd0;
    cyc();
    chk("dcp_pop_after_return", n_pop - n0, 1);
    chk("dcp_consumed", dcp0_credits, 0);
    chk("vc0_after_dcp_cmd", vc0_credits, 3);
    cyc();

    // Backpressure: ack low for 5 cycles
    cmd_ack = 1'b0;
    ce = mk(0, 0, 5); cf = mk(0, 0, 6);
    push(ce); push(cf);
    n0 = n_pop;
    cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_valid", cmd_valid, 1);
      chk("bp_data_stable", cmd_data, ce);
    end
    chk("bp_single_pop", n_pop - n0, 1);
    cmd_ack = 1'b1;
    cyc();
    chk("bp_next_valid", cmd_valid, 1);
    chk("bp_next_data", cmd_data, cf);
    chk("bp_second_pop", n_pop - n0, 2);
    repeat (2) cyc();

    // VC3 saturation
    vc3_credit_return = 4'd4;
    repeat (15) cyc();
    vc3_credit_return = 4'd2;
    cyc();
    chk("vc3_62", vc3_credits, 62);
    chk("no_ovf_62", credit_overflow_error, 0);
    vc3_credit_return = 4'd4;
    cyc();
    vc3_credit_return = 4'd0;
    chk("vc3_sat", vc3_credits, 63);
    chk("ovf_pulse", credit_overflow_error, 1);
    cyc();
    chk("ovf_cleared", credit_overflow_error, 0);
    chk("vc3_hold_max", vc3_credits, 63);

    // VC3 command consuming one data credit
    dcp0_credit_return = 4'd2;
    cyc();
    dcp0_credit_return = 4'd0;
    push(mk(1, 1, 7));
    n0 = n_pop;
    cyc();
    chk("vc3_pop", n_pop - n0, 1);
    chk("vc3_consumed", vc3_credits, 62);
    chk("dcp_vc3_consumed", dcp0_credits, 1);
    chk("vc0_untouched", vc0_credits, 1);
    cyc();

    // Pause with a held command
    cmd_ack = 1'b0;
    push(mk(0, 0, 8));
    cyc();
    chk("pause_held", cmd_valid, 1);
    pause = 1'b1;
    push(mk(0, 0, 9));
    vc0_credit_return = 4'd2;
    cyc();
    vc0_credit_return = 4'd0;
    n0 = n_pop;
    cmd_ack = 1'b1;
    cyc();
    chk("pause_ack_completes", cmd_valid, 0);
    repeat (3) cyc();
    chk("pause_no_pop", n_pop - n0, 0);
    chk("pause_fifo_kept", fq.size(), 1);
    pause = 1'b0;
    for (int i = 0; i < 5 && n_pop == n0; i++) cyc();
    chk("unpause_pop", n_pop - n0, 1);
    cyc();

    // Reset mid-handshake
    cmd_ack = 1'b0;
    push(mk(0, 0, 10));
    cyc();
    chk("pre_rst_valid", cmd_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("async_valid", cmd_valid, 0);
    chk("async_data", cmd_data, 0);
    chk("async_vc0", vc0_credits, 0);
    chk("async_vc3", vc3_credits, 0);
    chk("async_dcp0", dcp0_credits, 0);
    exp_q.delete();
    cyc();
    reset_n = 1'b1;
    cmd_ack = 1'b1;
    push(mk(0, 0, 11));
    n0 = n_pop;
    vc0_credit_return = 4'd3;
    cyc();
    vc0_credit_return = 4'd0;
    repeat (2) cyc();
    chk("init_no_pop", n_pop - n0, 0);
    chk("init_return_accepted", vc0_credits, 3);
    credit_init_vc0 = 6'd1; credit_init_vc3 = 6'd0; credit_init_dcp0 = 6'd0;
    credit_init_valid = 1'b1;
    vc0_credit_return = 4'd2;
    cyc();
    credit_init_valid = 1'b0;
    vc0_credit_return = 4'd0;
    chk("load_plus_return", vc0_credits, 3);
    cyc();
    chk("reinit_pop", n_pop - n0, 1);
    chk("reinit_vc0", vc0_credits, 2);
    cyc();

    // Illegal data-credit field stalls at head
    push(mk(0, 3, 12));
    push(mk(0, 0, 13));
    n0 = n_pop;
    repeat (4) cyc();
    chk("illegal_no_pop", n_pop - n0, 0);
    chk("illegal_head_kept", fq.size(), 2);
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ocx_tlx_framer_cmd_sched.md
OCX_TLX_FRAMER_CMD_SCHED -- requirements
Module: ocx_tlx_framer_cmd_sched

Interface
REQ-001 SHALL have parameter CREDIT_WIDTH, default 6, width of each credit counter.
REQ-002 SHALL have parameter CMD_WIDTH, default 172, width of one command word.
REQ-003 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert and active-low.
REQ-005 SHALL have port fifo_data  input  CMD_WIDTH  head entry of the upstream command FIFO.
REQ-006 SHALL have port fifo_data_available  input  1  FIFO holds at least one entry.
REQ-007 SHALL have port fifo_rd_done  output  1  one-cycle pop strobe to the FIFO.
REQ-008 SHALL have port credit_init_valid  input  1  load initial TL credits.
REQ-009 SHALL have ports credit_init_vc0, credit_init_vc3, credit_init_dcp0  input  CREDIT_WIDTH each  initial credit values.
REQ-010 SHALL have ports vc0_credit_return, vc3_credit_return, dcp0_credit_return  input  4 each  credits returned this cycle.
REQ-011 SHALL have port pause  input  1  framer request to stop issuing.
REQ-012 SHALL have ports cmd_valid  output  1, cmd_data  output  CMD_WIDTH, cmd_ack  input  1  valid/ack handshake to the flit packer.
REQ-013 SHALL have ports vc0_credits, vc3_credits, dcp0_credits  output  CREDIT_WIDTH each  current counter values.
REQ-014 SHALL have port credit_overflow_error  output  1  a credit counter would exceed its maximum.

Function
REQ-015 Command fields SHALL be: bit 171 = VC select (0 = VC0, 1 = VC3); bits 170:169 = data credits needed, 0..2; value 3 illegal.
REQ-016 FSM SHALL have states INIT, RUN, PAUSED; reset state INIT.
REQ-017 INIT -> RUN when credit_init_valid = 1; counters load credit_init_* on that edge.
REQ-018 RUN -> PAUSED when pause = 1; PAUSED -> RUN when pause = 0; credit_init_valid ignored outside INIT.
REQ-019 Issue condition SHALL be: state RUN, fifo_data_available, selected VC counter >= 1, dcp0_credits >= data-credit field, field != 3, and output register free (cmd_valid = 0 or cmd_ack = 1).
REQ-020 On issue, same cycle: fifo_rd_done = 1 (combinational); next edge: cmd_data <= fifo_data, cmd_valid <= 1.
REQ-021 fifo_rd_done SHALL never assert when fifo_data_available = 0.
REQ-022 cmd_valid and cmd_data SHALL hold stable until cmd_ack; cmd_ack with cmd_valid = 0 is ignored.
REQ-023 cmd_ack without a same-cycle issue SHALL clear cmd_valid next edge; ack with issue gives back-to-back output, one command per cycle maximum.
REQ-024 Pause SHALL stop new issues only; a held output command still completes on cmd_ack.
REQ-025 Each counter next value = current + return - consumed (consumed 1 per VC, field value for dcp0) in the same cycle, evaluated at CREDIT_WIDTH+1 bits.
REQ-026 If the sum exceeds 2^CREDIT_WIDTH-1, the counter SHALL saturate at the maximum and credit_overflow_error pulses 1 for that cycle.
REQ-027 Illegal field 3 at head SHALL stall, not pop; the head is never dropped.
REQ-028 Credit returns SHALL be accepted in all states, including INIT (added after load when simultaneous with credit_init_valid).

Reset
REQ-029 Asserting reset_n = 0 SHALL immediately force: state INIT, all counters 0, cmd_valid 0, cmd_data 0, fifo_rd_done 0, credit_overflow_error 0.
REQ-030 Reset mid-handshake SHALL discard the held command; no pop occurs until credits are reinitialised.

Verification
REQ-031 Reset, credit init vc0=2/vc3=0/dcp0=1, push 3 VC0 cmds with 0 data credits, cmd_ack tied 1 -> exactly 2 pops on consecutive cycles, vc0_credits = 0, third cmd held in FIFO.
REQ-032 VC0 cmd needing 2 data credits with dcp0_credits = 1 -> no pop; dcp0_credit_return = 1 -> pop next cycle, dcp0_credits = 0.
REQ-033 cmd_ack held 0 for 5 cycles with FIFO non-empty -> cmd_data stable, single pop total; ack pulse -> next command within 1 cycle.
REQ-034 vc3_credits = 62, return 4 with no consume -> vc3_credits = 63, credit_overflow_error = 1 for one cycle.
REQ-035 pause asserted with command held and FIFO non-empty -> held command completes on ack, no further pops until pause = 0.
REQ-036 reset_n dropped while cmd_valid = 1 -> cmd_valid = 0 without waiting for a clock edge; FSM returns to INIT.
